// File: rtl/test_port_pkg.sv
// Shared definitions for the test-result responder: register map,
// state encodings and the fixed result codes.
package test_port_pkg;

   localparam logic [1:0] REG_RESULT     = 2'd0;
   localparam logic [1:0] REG_CHECKPOINT = 2'd1;
   localparam logic [1:0] REG_COUNT      = 2'd2;
   localparam logic [1:0] REG_STATUS     = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

   localparam logic [23:0] CODE_TIMEOUT      = 24'hDEAD00;
   localparam logic [23:0] CODE_FAIL_DEFAULT = 24'hFFFFFF;

   // A failing RESULT write must never leave a zero code behind.
   function automatic logic [23:0] fail_code(input logic [31:0] wdata);
      return (wdata[23:0] == '0) ? CODE_FAIL_DEFAULT : wdata[23:0];
   endfunction

endpackage

// File: rtl/test_watchdog.sv
// Loadable 16-bit down-counter that ends a test which stops checkpointing.
module test_watchdog #(
   parameter int unsigned TIMEOUT = 500
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic load_i,
   output logic expired_o
);

   localparam logic [15:0] RELOAD = 16'(TIMEOUT);

   logic [15:0] cnt_q;

   // Reload on reset or request, otherwise count down while enabled and stop at 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= RELOAD;
      end else if (load_i) begin
         cnt_q <= RELOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 16'd1;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/test_port.sv
// Memory-mapped test-result responder: bus decode, checkpoint sequence
// checker and RUN/PASS/FAIL state machine driving test_ended/test_error.
module test_port
   import test_port_pkg::*;
#(
   parameter int unsigned TIMEOUT = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_stb,
   input  logic        io_we,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        io_ack,
   output logic        test_ended,
   output logic        test_error
);

   state_e      state_q;
   logic [15:0] seq_q;
   logic [15:0] seq_d;
   logic [23:0] code_q;
   logic        mismatch_q;
   logic        ack_q;
   logic [31:0] rdata_q;
   logic        ended_q;
   logic        error_q;

   logic        running;
   logic        wr_result;
   logic        wr_cp;
   logic        cp_ok;
   logic        wd_load;
   logic        wd_expired;
   logic [31:0] status;

   assign running   = (state_q == ST_RUN);
   assign wr_result = io_stb && io_we && (io_addr == REG_RESULT);
   assign wr_cp     = io_stb && io_we && (io_addr == REG_CHECKPOINT);
   assign cp_ok     = (io_wdata[31:16] == '0) && (io_wdata[15:0] == seq_q);
   assign seq_d     = seq_q + 16'd1;
   assign wd_load   = running && wr_cp && cp_ok;
   assign status    = {code_q, 5'b0, state_q, mismatch_q};

   test_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (running),
      .load_i    (wd_load),
      .expired_o (wd_expired)
   );

   // Bus response, sequence checker and state machine; flags are set in the
   // same edge as the state change so they line up with io_ack.
   // COUNT always equals the expected sequence number, so seq_q serves both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         seq_q      <= '0;
         code_q     <= '0;
         mismatch_q <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         ended_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         ack_q   <= io_stb;
         rdata_q <= '0;
         if (io_stb && !io_we) begin
            case (io_addr)
               REG_COUNT:  rdata_q <= {16'h0000, seq_q};
               REG_STATUS: rdata_q <= status;
               default:    rdata_q <= '0;
            endcase
         end

         if (running) begin
            if (wr_result) begin
               ended_q <= 1'b1;
               if (io_wdata == '0) begin
                  state_q <= ST_PASS;
                  code_q  <= '0;
               end else begin
                  state_q <= ST_FAIL;
                  code_q  <= fail_code(io_wdata);
                  error_q <= 1'b1;
               end
            end else if (wr_cp) begin
               if (cp_ok) begin
                  seq_q <= seq_d;
               end else begin
                  state_q    <= ST_FAIL;
                  mismatch_q <= 1'b1;
                  code_q     <= io_wdata[23:0];
                  ended_q    <= 1'b1;
                  error_q    <= 1'b1;
               end
            end else if (wd_expired) begin
               state_q <= ST_FAIL;
               code_q  <= CODE_TIMEOUT;
               ended_q <= 1'b1;
               error_q <= 1'b1;
            end
         end
      end
   end

   assign io_ack     = ack_q;
   assign io_rdata   = rdata_q;
   assign test_ended = ended_q;
   assign test_error = error_q;

endmodule

// File: tb/tb_test_port.sv
// Self-checking bench for test_port: a cycle model of the responder is
// compared against the DUT every cycle, plus directed literal checks.
module tb_test_port;

   localparam int unsigned TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        io_stb = 1'b0;
   logic        io_we = 1'b0;
   logic [1:0]  io_addr = 2'd0;
   logic [31:0] io_wdata = 32'h0;
   logic [31:0] io_rdata;
   logic        io_ack;
   logic        test_ended;
   logic        test_error;

   int n_cmp = 0;
   int n_bad = 0;

   test_port #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .io_stb     (io_stb),
      .io_we      (io_we),
      .io_addr    (io_addr),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .io_ack     (io_ack),
      .test_ended (test_ended),
      .test_error (test_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 running, 1 passed, 2 failed; idle = RUN cycles since the
   // last reset or accepted checkpoint; the test times out on the cycle after
   // idle reaches TO.
   int unsigned m_phase = 0;
   int unsigned m_idle  = 0;
   logic [23:0] m_code  = 24'h0;
   logic        m_mis   = 1'b0;
   logic [15:0] m_seq   = 16'h0;
   logic        e_ack   = 1'b0;
   logic [31:0] e_rdata = 32'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_idle <= 0; m_code <= 24'h0; m_mis <= 1'b0;
         m_seq <= 16'h0; e_ack <= 1'b0; e_rdata <= 32'h0;
      end else begin
         e_ack   <= io_stb;
         e_rdata <= 32'h0;
         if (io_stb && !io_we && io_addr == 2'd2) e_rdata <= {16'h0, m_seq};
         if (io_stb && !io_we && io_addr == 2'd3)
            e_rdata <= {m_code, 5'b0, 2'(m_phase), m_mis};
         if (m_phase == 0) begin
            if (io_stb && io_we && io_addr == 2'd0) begin
               if (io_wdata == 32'h0) m_phase <= 1;
               else begin
                  m_phase <= 2;
                  m_code  <= (io_wdata[23:0] != 24'h0) ? io_wdata[23:0] : 24'hFFFFFF;
               end
            end else if (io_stb && io_we && io_addr == 2'd1) begin
               if (io_wdata == {16'h0, m_seq}) begin
                  m_seq  <= m_seq + 16'd1;
                  m_idle <= 0;
               end else begin
                  m_phase <= 2; m_mis <= 1'b1; m_code <= io_wdata[23:0];
               end
            end else if (m_idle >= TO) begin
               m_phase <= 2; m_code <= 24'hDEAD00;
            end else begin
               m_idle <= m_idle + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ack", {31'h0, io_ack}, {31'h0, e_ack});
      if (e_ack) chk("rdata", io_rdata, e_rdata);
      chk("ended", {31'h0, test_ended}, {31'h0, m_phase != 0});
      chk("error", {31'h0, test_error}, {31'h0, m_phase == 2});
   end

   task automatic do_reset();
      rst = 1'b1;
      io_stb = 1'b0; io_we = 1'b0; io_addr = 2'd0; io_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      io_stb = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
      @(posedge clk);
      #1;
      io_stb = 1'b0; io_we = 1'b0; io_wdata = 32'h0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      io_stb = 1'b1; io_we = 1'b0; io_addr = a;
      @(posedge clk);
      #1;
      io_stb = 1'b0;
      d = io_rdata;
   endtask

   initial begin
      logic [31:0] v;
      int got;
      rst = 1'b1;
      do_reset();
      chk("reset_ack", {31'h0, io_ack}, 32'h0);
      chk("reset_ended", {31'h0, test_ended}, 32'h0);
      chk("reset_rdata", io_rdata, 32'h0);

      // RESULT 0 strobed at edge 10 after release
      repeat (9) @(posedge clk);
      #1;
      wr(2'd0, 32'h0);
      chk("pass_ack", {31'h0, io_ack}, 32'h1);
      chk("pass_ended", {31'h0, test_ended}, 32'h1);
      chk("pass_error", {31'h0, test_error}, 32'h0);
      rd(2'd3, v);
      chk("pass_status", v, 32'h0000_0002);
      wr(2'd0, 32'h7);
      rd(2'd3, v);
      chk("pass_ignore", v, 32'h0000_0002);
      rd(2'd0, v);
      chk("read_reg0_zero", v, 32'h0);

      // back-to-back checkpoints then pass
      do_reset();
      wr(2'd1, 32'd0); wr(2'd1, 32'd1); wr(2'd1, 32'd2);
      wr(2'd3, 32'hFFFF_FFFF);
      wr(2'd0, 32'h0);
      rd(2'd2, v);
      chk("count3", v, 32'd3);
      chk("count3_error", {31'h0, test_error}, 32'h0);

      // checkpoint mismatch
      do_reset();
      wr(2'd1, 32'd0);
      wr(2'd1, 32'd5);
      chk("mis_error", {31'h0, test_error}, 32'h1);
      rd(2'd3, v);
      chk("mis_status", v, 32'h0000_0505);

      // reset while a read ack is pending in FAIL
      io_stb = 1'b1; io_we = 1'b0; io_addr = 2'd3;
      @(posedge clk);
      #2 rst = 1'b1; io_stb = 1'b0;
      #1;
      chk("rst_ack", {31'h0, io_ack}, 32'h0);
      chk("rst_ended", {31'h0, test_ended}, 32'h0);
      chk("rst_error", {31'h0, test_error}, 32'h0);
      chk("rst_rdata", io_rdata, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      wr(2'd1, 32'd0);
      rd(2'd2, v);
      chk("seq_restart", v, 32'd1);

      // watchdog with no accesses
      do_reset();
      got = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (test_ended) begin
            got = k;
            break;
         end
      end
      chk("timeout_cycles", got, 32'd21);
      chk("timeout_error", {31'h0, test_error}, 32'h1);
      rd(2'd3, v);
      chk("timeout_status", v, 32'hDEAD_0004);

      // checkpoint on the expiry edge wins
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      wr(2'd1, 32'd0);
      chk("cp_vs_expiry", {31'h0, test_ended}, 32'h0);
      rd(2'd2, v);
      chk("cp_vs_expiry_count", v, 32'd1);
      wr(2'd0, 32'h0);
      chk("cp_then_pass", {31'h0, test_ended}, 32'h1);

      // RESULT write on the expiry edge wins
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      wr(2'd0, 32'h9);
      rd(2'd3, v);
      chk("result_vs_expiry", v, 32'h0000_0904);

      // fail write with zero low bits stores the default code
      do_reset();
      wr(2'd0, 32'h0100_0000);
      rd(2'd3, v);
      chk("default_code", v, 32'hFFFF_FF04);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
